// File: rtl/dds_sine_gen.sv
// dds_sine_gen -- direct digital synthesis sine source.
//
// A 32-bit phase accumulator advances by the active tuning word on every
// sample strobe. Its top PHASE_W bits, plus a per-sample phase offset, index a
// quarter-wave table that is folded by quadrant symmetry. The result is a
// signed sample with a fixed 3-cycle latency and a matching valid.
//
// The quarter-wave table is computed at elaboration with an integer-only
// constant function:
//   rom[i] = round(sin((i+0.5)*2*pi/2^PHASE_W) * (2^(DATA_W-1)-1))
// This is the same content as the sin_qw.hex image, but no file is needed, so
// there is no ROM_FILE parameter. The half-step offset makes the mirrored
// address exact. No table entry is zero, and negation never reaches
// -2^(DATA_W-1).
//
// Optional feature: define DDS_COS_OUT_EN to add the o_cos port. It is fed by
// a second table read port at phase p0 + 2^(PHASE_W-2) and is aligned with
// o_sin.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      synchronous reset, active low
//   i_en         sample strobe, one output sample per cycle high
//   i_ftw        frequency tuning word (staged)
//   i_ftw_ld     load i_ftw into the active tuning word
//   i_phase_off  phase offset added to the truncated phase, sampled with i_en
//   i_sync       restart phase at 0
//   o_vld        sample valid, 3 cycles after i_en
//   o_sin        signed sine sample (holds while no new sample)
//   o_cos        signed cosine sample (DDS_COS_OUT_EN only)
module dds_sine_gen #(
  parameter int ACC_W   = 32,
  parameter int PHASE_W = 10,
  parameter int DATA_W  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic [ACC_W-1:0]         i_ftw,
  input  logic                     i_ftw_ld,
  input  logic [PHASE_W-1:0]       i_phase_off,
  input  logic                     i_sync,
  output logic                     o_vld,
`ifdef DDS_COS_OUT_EN
  output logic signed [DATA_W-1:0] o_sin,
  output logic signed [DATA_W-1:0] o_cos
`else
  output logic signed [DATA_W-1:0] o_sin
`endif
);

  localparam int STAGES = 3;
  localparam int QW     = 2 ** (PHASE_W - 2);
  localparam int AW     = PHASE_W - 2;

  // pi in unsigned Q60 fixed point
  localparam logic [127:0] PI_Q60 = 128'h3243F6A8885A308D;

  // Rounded, scaled sine of the centre of quarter-wave bucket i.
  // Horner-form Taylor series in Q60 with 128-bit intermediates. Everything
  // stays positive over [0, pi/2), so plain unsigned arithmetic is exact
  // enough that the rounding matches a double-precision reference.
  function automatic logic [DATA_W-2:0] sin_entry(input int i);
    logic [127:0] one, amp, x, x2, t, s, r;
    one = 128'd1 << 60;
    amp = (128'd1 << (DATA_W - 1)) - 128'd1;
    x   = (128'(2 * i + 1) * PI_Q60) >> PHASE_W;
    x2  = (x * x) >> 60;
    t   = one;
    for (int k = 12; k >= 1; k--)
      t = one - ((x2 * t) >> 60) / 128'(2 * k * (2 * k + 1));
    s = (x * t) >> 60;
    r = (s * amp + (one >> 1)) >> 60;
    return (DATA_W-1)'(r);
  endfunction

  logic [DATA_W-2:0] rom [QW];

  for (genvar gi = 0; gi < QW; gi++) begin : g_rom
    localparam logic [DATA_W-2:0] ENTRY = sin_entry(gi);
    assign rom[gi] = ENTRY;
  end

  logic [ACC_W-1:0]   acc, ftw_r;
  logic [STAGES:0]    vld_pipe;   // [0] p0 valid ... [STAGES] output valid
  logic [PHASE_W-1:0] p0;
  logic [AW-1:0]      addr_s1;
  logic               neg_s1, neg_s2;
  logic [DATA_W-2:0]  rom_s2;
  logic signed [DATA_W-1:0] mag_s;

  // sync with a strobe starts this sample at phase 0
  logic [PHASE_W-1:0] acc_ph;
  assign acc_ph = i_sync ? '0 : acc[ACC_W-1 -: PHASE_W];

  assign mag_s = {1'b0, rom_s2};
  assign o_vld = vld_pipe[STAGES];

  // Control state and outputs: these are the only registers that reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc      <= '0;
      ftw_r    <= '0;
      vld_pipe <= '0;
      o_sin    <= '0;
    end else begin
      // the strobe in the same cycle still steps by the old ftw_r
      if (i_ftw_ld) ftw_r <= i_ftw;
      if (i_en)
        acc <= i_sync ? ftw_r : acc + ftw_r;
      else if (i_sync)
        acc <= '0;
      vld_pipe <= {vld_pipe[STAGES-1:0], i_en};
      if (vld_pipe[STAGES-1])
        o_sin <= neg_s2 ? -mag_s : mag_s;
    end
  end

  // Datapath stages (no reset needed; qualified by vld_pipe)
  always_ff @(posedge i_clk) begin
    if (i_en) p0 <= acc_ph + i_phase_off;
    // odd quadrants read the table mirrored; the upper half-wave is negated
    addr_s1 <= p0[PHASE_W-2] ? ~p0[AW-1:0] : p0[AW-1:0];
    neg_s1  <= p0[PHASE_W-1];
    rom_s2  <= rom[addr_s1];
    neg_s2  <= neg_s1;
  end

`ifdef DDS_COS_OUT_EN
  logic [PHASE_W-1:0] pc;
  logic [AW-1:0]      addr_c1;
  logic               neg_c1, neg_c2;
  logic [DATA_W-2:0]  rom_c2;
  logic signed [DATA_W-1:0] mag_c;

  // cosine is the sine a quarter wave ahead
  assign pc    = p0 + PHASE_W'(QW);
  assign mag_c = {1'b0, rom_c2};

  always_ff @(posedge i_clk) begin
    addr_c1 <= pc[PHASE_W-2] ? ~pc[AW-1:0] : pc[AW-1:0];
    neg_c1  <= pc[PHASE_W-1];
    rom_c2  <= rom[addr_c1];
    neg_c2  <= neg_c1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      o_cos <= '0;
    else if (vld_pipe[STAGES-1])
      o_cos <= neg_c2 ? -mag_c : mag_c;
  end
`endif

endmodule
